mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the mem_responder word store.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, wr, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, wr, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and a single-cycle
// completion pulse; misaligned or out-of-range requests are rejected with err.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  mem_responder_if.slave  bus
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic            addr_bad;

  logic [31:0]     mem_q [DEPTH_WORDS];

  assign addr_bad = (bus.addr[1:0] != 2'b00) || ({2'b00, bus.addr[31:2]} >= DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          idx_d   = bus.addr[IdxW+1:2];
          wdata_d = bus.wdata;
          if (addr_bad) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      StResp: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.ready = (state_q == StResp);
  assign bus.busy  = (state_q != StIdle);
  assign bus.err   = err_q & bus.ready;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  mem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (2)
  ) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifa)
  );

  mem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (0)
  ) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifb)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      ifb.req = r; ifb.wr = w; ifb.addr = a; ifb.wdata = d;
    end else begin
      ifa.req = r; ifa.wr = w; ifa.addr = a; ifa.wdata = d;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ifb.ready : ifa.ready;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic erro(input bit sel);
    return sel ? ifb.err : ifa.err;
  endfunction
  function automatic logic [31:0] rdat(input bit sel);
    return sel ? ifb.rdata : ifa.rdata;
  endfunction

  // Single request; lat counts edges after acceptance edge N until ready is seen.
  task automatic transact(input bit sel, input string tag, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rdata);
    int lat;
    @(posedge clk); #1;
    drive(sel, 1'b1, w, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq({tag, ".busy"}, 32'(bsy(sel)), 32'h1);
    lat = 0;
    while (!rdy(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".err"}, 32'(erro(sel)), 32'(exp_err));
    check_eq({tag, ".rdata"}, rdat(sel), exp_rdata);
    @(posedge clk); #1;
    check_eq({tag, ".err_low"}, 32'(erro(sel)), 32'h0);
    check_eq({tag, ".idle"}, 32'(bsy(sel)), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    check_eq("rst.ready", 32'(ifa.ready), 32'h0);
    check_eq("rst.busy", 32'(ifa.busy), 32'h0);
    check_eq("rst.err", 32'(ifa.err), 32'h0);
    check_eq("rst.rdata", ifa.rdata, 32'h0);
    check_eq("rst.b_busy", 32'(ifb.busy), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    transact(1'b0, "wr10", 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0);
    transact(1'b0, "rd10", 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);
    repeat (10) @(posedge clk);
    #1 check_eq("rd10.hold", ifa.rdata, 32'hDEADBEEF);

    transact(1'b0, "misalign", 1'b0, 32'h13, 32'h0, 0, 1'b1, 32'hDEADBEEF);
    transact(1'b0, "oor_rd", 1'b0, 32'h400, 32'h0, 0, 1'b1, 32'hDEADBEEF);
    transact(1'b0, "wr00", 1'b1, 32'h0, 32'h01020304, 3, 1'b0, 32'hDEADBEEF);
    transact(1'b0, "oor_wr", 1'b1, 32'h400, 32'h0BADF00D, 0, 1'b1, 32'hDEADBEEF);
    transact(1'b0, "mis_wr", 1'b1, 32'h11, 32'h0BADF00D, 0, 1'b1, 32'hDEADBEEF);
    transact(1'b0, "rd00", 1'b0, 32'h0, 32'h0, 3, 1'b0, 32'h01020304);
    transact(1'b0, "rd10b", 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);

    // Req held high with junk inputs during WAIT; second request is a read of 0x30.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    @(posedge clk); #1;
    for (int k = 0; k <= 9; k++) begin
      if (k >= 1) begin
        @(posedge clk); #1;
        check_eq($sformatf("hold.ready%0d", k), 32'(ifa.ready), 32'((k == 3) || (k == 8)));
      end
      if (k == 4)
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
      else if (k >= 8)
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      else
        drive(1'b0, 1'b1, 1'b1, (k % 2 == 1) ? 32'h34 : 32'h38, 32'h11110000 | 32'(k));
    end
    check_eq("hold.rdata", ifa.rdata, 32'hCAFEF00D);
    transact(1'b0, "rd30", 1'b0, 32'h30, 32'h0, 3, 1'b0, 32'hCAFEF00D);

    // Reset in WAIT must abort the write.
    transact(1'b0, "wr20", 1'b1, 32'h20, 32'hA5A5A5A5, 3, 1'b0, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("abort.busy_pre", 32'(ifa.busy), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort.ready", 32'(ifa.ready), 32'h0);
    check_eq("abort.busy", 32'(ifa.busy), 32'h0);
    check_eq("abort.err", 32'(ifa.err), 32'h0);
    check_eq("abort.rdata", ifa.rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort.busy_hold", 32'(ifa.busy), 32'h0);
    rst_n = 1'b1;
    transact(1'b0, "rd20", 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'hA5A5A5A5);
    transact(1'b0, "rd10c", 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);

    // Zero-wait instance.
    transact(1'b1, "w0_wr", 1'b1, 32'h0, 32'h00000001, 1, 1'b0, 32'h0);
    transact(1'b1, "w0_rd", 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h00000001);
    transact(1'b1, "w0_oor", 1'b0, 32'h404, 32'h0, 0, 1'b1, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
